// File: rtl/pipe_buf_pkg.sv
// Shared types and constants for the inter-stage pipeline buffer.
// Field index names follow the ordering of a typical pipeline bundle.
package pipe_buf_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    localparam int DEF_FIELD_W    = 16;
    localparam int DEF_NUM_FIELDS = 6;

    localparam int FLD_WB     = 0;
    localparam int FLD_MEM    = 1;
    localparam int FLD_ALU_HI = 2;
    localparam int FLD_ALU_LO = 3;
    localparam int FLD_SEXT   = 4;
    localparam int FLD_INST   = 5;

endpackage

// File: rtl/pipe_buf_entry.sv
// One bundle-wide storage entry with clear (priority) and load enables.
// The clear value replicates RST_VAL into every field.
module pipe_buf_entry
    import pipe_buf_pkg::*;
#(
    parameter int                 FIELD_W    = DEF_FIELD_W,
    parameter int                 NUM_FIELDS = DEF_NUM_FIELDS,
    parameter logic [FIELD_W-1:0] RST_VAL    = '0
) (
    input  logic                          clk,
    input  logic                          clr_i,
    input  logic                          ld_i,
    input  logic [FIELD_W*NUM_FIELDS-1:0] d_i,
    output logic [FIELD_W*NUM_FIELDS-1:0] q_o
);

    logic [FIELD_W*NUM_FIELDS-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= {NUM_FIELDS{RST_VAL}};
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid, halt and flush.
// Optional stall/bubble counters are built when PIPE_STAGE_BUFFER_STATS_EN is defined.
module pipe_stage_buffer
    import pipe_buf_pkg::*;
#(
    parameter int                 FIELD_W    = DEF_FIELD_W,
    parameter int                 NUM_FIELDS = DEF_NUM_FIELDS,
    parameter logic [FIELD_W-1:0] RST_VAL    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          halt,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FIELD_W*NUM_FIELDS-1:0] in_fields,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FIELD_W*NUM_FIELDS-1:0] out_fields,
    output logic [1:0]                    occupancy
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    ,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   bubble_cnt
`endif
);

    localparam int BUS_W = FIELD_W * NUM_FIELDS;

    buf_state_e state_q, state_d;

    logic             push, pop, clr;
    logic             head_ld, skid_ld, head_from_skid;
    logic [BUS_W-1:0] head_d, skid_q;

    assign in_ready  = (state_q != ST_FULL) & ~halt & ~flush;
    assign out_valid = (state_q != ST_EMPTY) & ~halt;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign clr       = rst | flush;
    assign occupancy = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        head_ld        = 1'b0;
        skid_ld        = 1'b0;
        head_from_skid = 1'b0;
        if (clr) begin
            state_d = ST_EMPTY;
        end else if (!halt) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_ld = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_ld = 1'b1;
                    end else if (push) begin
                        skid_ld = 1'b1;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move data
                    if (pop) begin
                        head_ld        = 1'b1;
                        head_from_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_q : in_fields;

    pipe_buf_entry #(
        .FIELD_W    (FIELD_W),
        .NUM_FIELDS (NUM_FIELDS),
        .RST_VAL    (RST_VAL)
    ) u_head (
        .clk   (clk),
        .clr_i (clr),
        .ld_i  (head_ld),
        .d_i   (head_d),
        .q_o   (out_fields)
    );

    pipe_buf_entry #(
        .FIELD_W    (FIELD_W),
        .NUM_FIELDS (NUM_FIELDS),
        .RST_VAL    (RST_VAL)
    ) u_skid (
        .clk   (clk),
        .clr_i (clr),
        .ld_i  (skid_ld),
        .d_i   (in_fields),
        .q_o   (skid_q)
    );

`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic [15:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (halt && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (!out_valid && !halt && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed, table-driven bench for pipe_stage_buffer.
// Stats checks are compiled when PIPE_STAGE_BUFFER_STATS_EN is defined.
module tb_pipe_stage_buffer;
    import pipe_buf_pkg::*;

    localparam int FW    = 16;
    localparam int NF    = 6;
    localparam int BUS_W = FW * NF;

    logic             clk = 1'b0;
    logic             rst, halt, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [BUS_W-1:0] in_fields, out_fields;
    logic [1:0]       occupancy;
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic [15:0]      stall_cnt, bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(
        .FIELD_W    (FW),
        .NUM_FIELDS (NF),
        .RST_VAL    (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fields  (in_fields),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fields (out_fields),
        .occupancy  (occupancy)
`ifdef PIPE_STAGE_BUFFER_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    typedef struct {
        logic        halt;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [15:0] din;
        logic        e_ir;
        logic        e_ov;
        logic [1:0]  e_occ;
        logic [15:0] e_out;
    } vec_t;

    vec_t vecs[$];

    // Each field gets a distinct pattern so field swaps are visible; 0 maps to RST_VAL.
    function automatic logic [BUS_W-1:0] mk(input logic [15:0] d);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int k = 0; k < NF; k++) begin
            r[k*FW +: FW] = (d == 16'h0) ? 16'h0 : (d ^ 16'(k << 12));
        end
        return r;
    endfunction

    function automatic vec_t v(input logic h, input logic f, input logic iv,
                               input logic ordy, input logic [15:0] din,
                               input logic ir, input logic ov,
                               input logic [1:0] occ, input logic [15:0] eo);
        vec_t t;
        t.halt = h; t.flush = f; t.iv = iv; t.ordy = ordy; t.din = din;
        t.e_ir = ir; t.e_ov = ov; t.e_occ = occ; t.e_out = eo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [BUS_W-1:0] act,
                       input logic [BUS_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic f, input logic iv,
                         input logic ordy, input logic [15:0] din);
        halt      = h;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        in_fields = mk(din);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_occ", BUS_W'(occupancy), BUS_W'(2'd0));
        chk("rst_ov", BUS_W'(out_valid), BUS_W'(1'b0));
        chk("rst_ir", BUS_W'(in_ready), BUS_W'(1'b1));
        chk("rst_out", out_fields, '0);

        vecs.push_back(v(0, 0, 1, 1, 16'h0001, 1, 0, 0, 16'h0000));
        for (int k = 2; k <= 8; k++) begin
            vecs.push_back(v(0, 0, 1, 1, 16'(k), 1, 1, 1, 16'(k - 1)));
        end
        vecs.push_back(v(0, 0, 0, 1, 16'h0, 1, 1, 1, 16'h0008));
        vecs.push_back(v(0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h0008));
        // skid fill and drain
        vecs.push_back(v(0, 0, 1, 0, 16'hAAAA, 1, 0, 0, 16'h0008));
        vecs.push_back(v(0, 0, 1, 0, 16'hBBBB, 1, 1, 1, 16'hAAAA));
        vecs.push_back(v(0, 0, 1, 0, 16'hCCCC, 0, 1, 2, 16'hAAAA));
        vecs.push_back(v(0, 0, 0, 1, 16'h0, 0, 1, 2, 16'hAAAA));
        vecs.push_back(v(0, 0, 0, 1, 16'h0, 1, 1, 1, 16'hBBBB));
        vecs.push_back(v(0, 0, 0, 0, 16'h0, 1, 0, 0, 16'hBBBB));
        // halt while full
        vecs.push_back(v(0, 0, 1, 0, 16'h1111, 1, 0, 0, 16'hBBBB));
        vecs.push_back(v(0, 0, 1, 0, 16'h2222, 1, 1, 1, 16'h1111));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(v(1, 0, 1, 1, 16'h3333, 0, 0, 2, 16'h1111));
        end
        vecs.push_back(v(0, 0, 0, 1, 16'h0, 0, 1, 2, 16'h1111));
        vecs.push_back(v(0, 0, 0, 1, 16'h0, 1, 1, 1, 16'h2222));
        // flush with halt and push
        vecs.push_back(v(0, 0, 1, 0, 16'h4444, 1, 0, 0, 16'h2222));
        vecs.push_back(v(0, 0, 1, 0, 16'h5555, 1, 1, 1, 16'h4444));
        vecs.push_back(v(1, 1, 1, 0, 16'h6666, 0, 0, 2, 16'h4444));
        vecs.push_back(v(0, 0, 0, 1, 16'h0, 1, 0, 0, 16'h0000));
        vecs.push_back(v(0, 0, 1, 1, 16'h7777, 1, 0, 0, 16'h0000));
        vecs.push_back(v(0, 0, 0, 1, 16'h0, 1, 1, 1, 16'h7777));
        vecs.push_back(v(0, 0, 0, 0, 16'h0, 1, 0, 0, 16'h7777));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].halt, vecs[i].flush, vecs[i].iv, vecs[i].ordy, vecs[i].din);
            #1;
            chk($sformatf("v%0d_ir", i), BUS_W'(in_ready), BUS_W'(vecs[i].e_ir));
            chk($sformatf("v%0d_ov", i), BUS_W'(out_valid), BUS_W'(vecs[i].e_ov));
            chk($sformatf("v%0d_occ", i), BUS_W'(occupancy), BUS_W'(vecs[i].e_occ));
            chk($sformatf("v%0d_out", i), out_fields, mk(vecs[i].e_out));
            @(negedge clk);
        end

`ifdef PIPE_STAGE_BUFFER_STATS_EN
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        halt = 1'b1;
        repeat (4) @(negedge clk);
        halt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("stall_cnt_4", BUS_W'(stall_cnt), BUS_W'(16'd4));
        chk("bubble_cnt_3", BUS_W'(bubble_cnt), BUS_W'(16'd3));
        halt = 1'b1;
        repeat (16'hFFFE - 16'd4) @(negedge clk);
        #1;
        chk("stall_cnt_fffe", BUS_W'(stall_cnt), BUS_W'(16'hFFFE));
        repeat (5) @(negedge clk);
        #1;
        chk("stall_cnt_sat", BUS_W'(stall_cnt), BUS_W'(16'hFFFF));
        chk("bubble_cnt_hold", BUS_W'(bubble_cnt), BUS_W'(16'd3));
        halt = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
